rvee_mem: RTL and testbench
===========================

Name: rvee_mem

Overview:
Memory stage of the rvee pipeline. It is the consumer end of the exec-to-mem handshake and drives the ready signal of that handshake. It has two jobs:
- Pass ALU results through to writeback.
- Perform load/store accesses on a single-outstanding data bus, with lane alignment, byte enables and load sign/zero extension.

Results go to a registered writeback port, which always accepts them.

Parameters:
XLEN, 32, datapath width; only 32 is supported (RV32). Any other value is an elaboration error.

Ports:
- clk  input  1  clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ex  interface  -  rvee_exec_if.mem_port.
  - Drives ready.
  - Reads valid, pc, rd_we, rd, result, mem_load, mem_store, mem_data, mem_size, mem_sext.
- dbus_req_valid  output  1  data bus request valid.
- dbus_req_ready  input  1  request accepted when both valid and ready are high.
- dbus_addr  output  XLEN  word-aligned address, result & ~3.
- dbus_we  output  1  1 = store, 0 = load.
- dbus_wdata  output  XLEN  lane-replicated store data.
- dbus_be  output  4  byte enables; all ones for loads.
- dbus_rsp_valid  input  1  one-cycle response/ack; exactly one per accepted request; stores are acked too.
- dbus_rdata  input  XLEN  load data, valid with dbus_rsp_valid.
- wb_valid  output  1  one-cycle writeback pulse.
- wb_pc  output  XLEN  pc of the retiring op.
- wb_rd_we  output  1  register write enable.
- wb_rd  output  5  destination register.
- wb_data  output  XLEN  result or extended load data.
- wb_fault  output  1  misaligned load/store; qualified by wb_valid.

Behaviour:
Exec-side contract:
- Exec holds valid and the whole payload stable until done.
- ex.result is the effective address for memory ops.
- mem_size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.

Misalignment:
- An access is misaligned when size is half and addr[0]=1, or size is word and addr[1:0]!=0.

FSM states: IDLE, REQ, RESP. Reset puts the FSM in IDLE.

IDLE:
- No valid: no action.
- Valid, not a memory op: ready=1 combinationally. The next cycle drives wb_valid=1, wb_data=result, wb_rd_we=rd_we, wb_fault=0.
- Valid, misaligned memory op: ready=1 and no bus request. The next cycle drives wb_valid=1, wb_fault=1, wb_rd_we=0.
- Valid, aligned memory op: ready=0. Go to REQ. Register dbus_req_valid=1 along with addr, we, wdata and be.

REQ:
- dbus_req_valid stays high and the payload stays stable until dbus_req_ready.
- On acceptance, drop dbus_req_valid and go to RESP.

RESP:
- Wait for dbus_rsp_valid. In that cycle, ready=1 combinationally so that ex.done fires, and the FSM returns to IDLE.
- The next cycle drives the wb outputs.
  - Load: wb_rd_we=rd_we, wb_data=extended load data.
  - Store: wb_rd_we=0, wb_data=0.

Timing:
- ready is never asserted in REQ.
- Minimum memory-op latency, valid to wb_valid: valid seen in IDLE, then REQ with zero-wait acceptance, then RESP with a same-cycle response, then wb_valid the next cycle.
- Back-to-back non-memory ops retire at one per cycle.

Store lanes (sh = result[1:0]):
- Byte: wdata = {4{mem_data[7:0]}}, be = 4'b0001 << sh.
- Half: wdata = {2{mem_data[15:0]}}, be = 4'b0011 << sh.
- Word: wdata = mem_data, be = 4'b1111.

Load extract:
- x = dbus_rdata >> (8*sh).
- Byte: x[7:0], sign-extended if mem_sext, else zero-extended.
- Half: x[15:0], extended the same way.
- Word: x.

Boundary conditions:
- wb_valid is exactly one cycle per retired op, never twice for the same op.
- dbus_rsp_valid outside RESP is ignored and must not change state.
- rst mid-operation: FSM goes to IDLE and dbus_req_valid=0. Any response in flight is dropped. The bus fabric is reset on the same rst.

Reset values:
- dbus_req_valid=0, dbus_addr=0, dbus_we=0, dbus_wdata=0, dbus_be=0.
- wb_valid=0, wb_pc=0, wb_rd_we=0, wb_rd=0, wb_data=0, wb_fault=0.
- ready is combinational and is 0 while rst=1.

Decomposition:
- rvee_mem_pkg holds:
  - Size constants MEM_SIZE_B=2'd0, MEM_SIZE_H=2'd1, MEM_SIZE_W=2'd2.
  - The state enum (IDLE, REQ, RESP).
  - The misalignment check function.
- One combinational sub-module, rvee_mem_align, does store lane replication, byte-enable generation and load extract/extension. It is unit-testable on its own.
- The FSM, the dbus registers and the wb registers stay in rvee_mem.

Test Plan:
- ALU passthrough: three back-to-back non-memory ops with rd=1,2,3 and result 0x11,0x22,0x33 -> ready=1 each cycle, and wb_valid on three consecutive cycles with matching rd and data.
- Load byte sext: addr 0x1003, size 0, sext=1, rdata 0x80FF_FF00 -> dbus_addr 0x1000, be 4'b1111, wb_data 0xFFFF_FF80.
- Load half zext: addr 0x2002, size 1, sext=0, rdata 0x8001_1234 -> wb_data 0x0000_8001.
- Store half: addr 0x3002, mem_data 0xDEAD_BEEF -> wdata 0xBEEF_BEEF, be 4'b1100, dbus_we=1, wb_rd_we=0.
- Wait states and misalignment:
  - Hold dbus_req_ready=0 for 3 cycles -> request payload stable and ready=0 throughout.
  - Then a word load at 0x4001 -> no request issued, wb_fault=1, wb_rd_we=0.
- Reset in RESP: assert rst for 1 cycle, then send a stray dbus_rsp_valid -> no wb_valid, FSM in IDLE, and the next op completes normally.

Source files
------------

// File: rtl/rvee_mem_pkg.sv
// rvee memory stage: shared sizes, FSM states and helpers.
// Imported by the exec handshake interface and the mem stage.
package rvee_mem_pkg;

  localparam int RV_XLEN = 32;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic m;
    m = 1'b0;
    if (size == MEM_SIZE_H)
      m = a[0];
    else if (size != MEM_SIZE_B)
      m = (a != 2'b00);
    return m;
  endfunction

endpackage

// File: rtl/rvee_exec_if.sv
// rvee exec-to-mem valid/ready handshake.
// Exec holds valid and payload stable until ready.
interface rvee_exec_if;
  import rvee_mem_pkg::*;

  logic               valid;
  logic               ready;
  logic [RV_XLEN-1:0] pc;
  logic               rd_we;
  logic [4:0]         rd;
  logic [RV_XLEN-1:0] result;
  logic               mem_load;
  logic               mem_store;
  logic [RV_XLEN-1:0] mem_data;
  logic [1:0]         mem_size;
  logic               mem_sext;

  modport exec_port (
    output valid, pc, rd_we, rd, result,
    output mem_load, mem_store, mem_data,
    output mem_size, mem_sext,
    input  ready
  );

  modport mem_port (
    input  valid, pc, rd_we, rd, result,
    input  mem_load, mem_store, mem_data,
    input  mem_size, mem_sext,
    output ready
  );

endinterface

// File: rtl/rvee_mem_align.sv
// rvee mem lane logic: store replication, byte
// enables, load extract and sign/zero extension.
module rvee_mem_align
  import rvee_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  sh_i,
  input  logic        sext_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] ld_ext_o
);

  logic [31:0] x;

  // Lane placement for stores, lane pick for loads
  always_comb begin
    x        = ld_data_i >> {sh_i, 3'b000};
    wdata_o  = st_data_i;
    be_o     = 4'b1111;
    ld_ext_o = x;
    case (size_i)
      MEM_SIZE_B: begin
        wdata_o  = {4{st_data_i[7:0]}};
        be_o     = 4'b0001 << sh_i;
        ld_ext_o = {{24{sext_i & x[7]}}, x[7:0]};
      end
      MEM_SIZE_H: begin
        wdata_o  = {2{st_data_i[15:0]}};
        be_o     = 4'b0011 << sh_i;
        ld_ext_o = {{16{sext_i & x[15]}}, x[15:0]};
      end
      default: begin
        wdata_o  = st_data_i;
        be_o     = 4'b1111;
        ld_ext_o = x;
      end
    endcase
  end

endmodule

// File: rtl/rvee_mem.sv
// rvee memory stage: ALU passthrough plus a
// single-outstanding load/store on the data bus.
module rvee_mem
  import rvee_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  rvee_exec_if.mem_port   ex,
  output logic            dbus_req_valid,
  input  logic            dbus_req_ready,
  output logic [XLEN-1:0] dbus_addr,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [3:0]      dbus_be,
  input  logic            dbus_rsp_valid,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_pc,
  output logic            wb_rd_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_fault
);

  if (XLEN != 32) begin : g_xlen_bad
    $error("rvee_mem: only XLEN=32 is supported");
  end

  mem_state_e  state_q;
  logic        is_mem;
  logic        mis;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] al_ld;

  assign is_mem = ex.mem_load | ex.mem_store;
  assign mis    = misaligned(ex.mem_size, ex.result[1:0]);

  rvee_mem_align u_align (
    .size_i    (ex.mem_size),
    .sh_i      (ex.result[1:0]),
    .sext_i    (ex.mem_sext),
    .st_data_i (ex.mem_data),
    .ld_data_i (dbus_rdata),
    .wdata_o   (al_wdata),
    .be_o      (al_be),
    .ld_ext_o  (al_ld)
  );

  // Handshake completes in IDLE for non-bus ops, in RESP on the ack
  always_comb begin
    ex.ready = 1'b0;
    if (!rst && ex.valid) begin
      case (state_q)
        IDLE:    ex.ready = !is_mem || mis;
        RESP:    ex.ready = dbus_rsp_valid;
        default: ex.ready = 1'b0;
      endcase
    end
  end

  // FSM with registered dbus request and writeback port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      dbus_req_valid <= 1'b0;
      dbus_addr      <= '0;
      dbus_we        <= 1'b0;
      dbus_wdata     <= '0;
      dbus_be        <= '0;
      wb_valid       <= 1'b0;
      wb_pc          <= '0;
      wb_rd_we       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      wb_fault       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex.valid) begin
            if (!is_mem || mis) begin
              wb_valid <= 1'b1;
              wb_pc    <= ex.pc;
              wb_rd    <= ex.rd;
              wb_fault <= is_mem;
              wb_rd_we <= is_mem ? 1'b0 : ex.rd_we;
              wb_data  <= is_mem ? '0 : ex.result;
            end else begin
              state_q        <= REQ;
              dbus_req_valid <= 1'b1;
              dbus_addr      <= {ex.result[XLEN-1:2], 2'b00};
              dbus_we        <= ex.mem_store;
              dbus_wdata     <= al_wdata;
              dbus_be        <= ex.mem_store ? al_be : 4'b1111;
            end
          end
        end
        REQ: begin
          if (dbus_req_ready) begin
            dbus_req_valid <= 1'b0;
            state_q        <= RESP;
          end
        end
        RESP: begin
          if (dbus_rsp_valid) begin
            state_q  <= IDLE;
            wb_valid <= 1'b1;
            wb_pc    <= ex.pc;
            wb_rd    <= ex.rd;
            wb_fault <= 1'b0;
            wb_rd_we <= ex.mem_load & ex.rd_we;
            wb_data  <= ex.mem_load ? al_ld : '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvee_mem.sv
// rvee_mem bench: directed vectors with
// hand-computed expectations.
module tb_rvee_mem;
  import rvee_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbus_req_valid;
  logic        dbus_req_ready;
  logic [31:0] dbus_addr;
  logic        dbus_we;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_rsp_valid;
  logic [31:0] dbus_rdata;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rd_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_fault;

  int n_tests = 0;
  int n_fail  = 0;

  rvee_exec_if ex_if ();

  rvee_mem #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex             (ex_if.mem_port),
    .dbus_req_valid (dbus_req_valid),
    .dbus_req_ready (dbus_req_ready),
    .dbus_addr      (dbus_addr),
    .dbus_we        (dbus_we),
    .dbus_wdata     (dbus_wdata),
    .dbus_be        (dbus_be),
    .dbus_rsp_valid (dbus_rsp_valid),
    .dbus_rdata     (dbus_rdata),
    .wb_valid       (wb_valid),
    .wb_pc          (wb_pc),
    .wb_rd_we       (wb_rd_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_fault       (wb_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_if.valid     = 1'b0;
    ex_if.pc        = '0;
    ex_if.rd_we     = 1'b0;
    ex_if.rd        = '0;
    ex_if.result    = '0;
    ex_if.mem_load  = 1'b0;
    ex_if.mem_store = 1'b0;
    ex_if.mem_data  = '0;
    ex_if.mem_size  = '0;
    ex_if.mem_sext  = 1'b0;
  endtask

  task automatic mem_op(
    input string       tag,
    input logic [31:0] a,
    input logic [1:0]  sz,
    input logic        sx,
    input logic        st,
    input logic [31:0] md,
    input logic [31:0] rdata,
    input int          waits,
    input logic [31:0] e_addr,
    input logic [3:0]  e_be,
    input logic [31:0] e_wdata,
    input logic        e_rdwe,
    input logic [31:0] e_wb
  );
    ex_if.valid     = 1'b1;
    ex_if.pc        = a + 32'h100;
    ex_if.rd_we     = 1'b1;
    ex_if.rd        = 5'd7;
    ex_if.result    = a;
    ex_if.mem_load  = !st;
    ex_if.mem_store = st;
    ex_if.mem_data  = md;
    ex_if.mem_size  = sz;
    ex_if.mem_sext  = sx;
    dbus_req_ready  = 1'b0;
    #1;
    chk({tag, ".rdy_idle"}, 32'(ex_if.ready), 32'd0);
    tick();
    chk({tag, ".reqv"}, 32'(dbus_req_valid), 32'd1);
    chk({tag, ".addr"}, dbus_addr, e_addr);
    chk({tag, ".be"}, 32'(dbus_be), 32'(e_be));
    chk({tag, ".we"}, 32'(dbus_we), 32'(st));
    if (st) chk({tag, ".wdata"}, dbus_wdata, e_wdata);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk({tag, ".w_reqv"}, 32'(dbus_req_valid), 32'd1);
      chk({tag, ".w_addr"}, dbus_addr, e_addr);
      chk({tag, ".w_be"}, 32'(dbus_be), 32'(e_be));
      chk({tag, ".w_rdy"}, 32'(ex_if.ready), 32'd0);
    end
    dbus_req_ready = 1'b1;
    tick();
    dbus_req_ready = 1'b0;
    chk({tag, ".reqv_drop"}, 32'(dbus_req_valid), 32'd0);
    chk({tag, ".rdy_resp0"}, 32'(ex_if.ready), 32'd0);
    dbus_rsp_valid = 1'b1;
    dbus_rdata     = rdata;
    #1;
    chk({tag, ".rdy_ack"}, 32'(ex_if.ready), 32'd1);
    tick();
    dbus_rsp_valid = 1'b0;
    idle_ex();
    chk({tag, ".wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, ".wb_rdwe"}, 32'(wb_rd_we), 32'(e_rdwe));
    chk({tag, ".wb_data"}, wb_data, e_wb);
    chk({tag, ".wb_fault"}, 32'(wb_fault), 32'd0);
    chk({tag, ".wb_pc"}, wb_pc, a + 32'h100);
    tick();
    chk({tag, ".wbv_once"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    dbus_req_ready = 1'b0;
    dbus_rsp_valid = 1'b0;
    dbus_rdata     = '0;
    idle_ex();
    tick();
    tick();
    chk("rst.rdy", 32'(ex_if.ready), 32'd0);
    chk("rst.reqv", 32'(dbus_req_valid), 32'd0);
    chk("rst.addr", dbus_addr, 32'd0);
    chk("rst.be", 32'(dbus_be), 32'd0);
    chk("rst.wbv", 32'(wb_valid), 32'd0);
    chk("rst.wbdata", wb_data, 32'd0);
    chk("rst.wbpc", wb_pc, 32'd0);
    rst = 1'b0;
    tick();

    ex_if.valid  = 1'b1;
    ex_if.rd_we  = 1'b1;
    ex_if.rd     = 5'd1;
    ex_if.result = 32'h11;
    #1;
    chk("alu1.rdy", 32'(ex_if.ready), 32'd1);
    tick();
    chk("alu1.wbv", 32'(wb_valid), 32'd1);
    chk("alu1.rd", 32'(wb_rd), 32'd1);
    chk("alu1.data", wb_data, 32'h11);
    chk("alu1.rdwe", 32'(wb_rd_we), 32'd1);
    ex_if.rd     = 5'd2;
    ex_if.result = 32'h22;
    #1;
    chk("alu2.rdy", 32'(ex_if.ready), 32'd1);
    tick();
    chk("alu2.wbv", 32'(wb_valid), 32'd1);
    chk("alu2.rd", 32'(wb_rd), 32'd2);
    chk("alu2.data", wb_data, 32'h22);
    ex_if.rd     = 5'd3;
    ex_if.result = 32'h33;
    #1;
    chk("alu3.rdy", 32'(ex_if.ready), 32'd1);
    tick();
    idle_ex();
    chk("alu3.wbv", 32'(wb_valid), 32'd1);
    chk("alu3.rd", 32'(wb_rd), 32'd3);
    chk("alu3.data", wb_data, 32'h33);
    tick();
    chk("alu.wbv_end", 32'(wb_valid), 32'd0);

    mem_op("lb", 32'h1003, MEM_SIZE_B, 1'b1, 1'b0, 32'h0,
           32'h80FF_FF00, 0, 32'h1000, 4'b1111, 32'h0,
           1'b1, 32'hFFFF_FF80);
    mem_op("lhu", 32'h2002, MEM_SIZE_H, 1'b0, 1'b0, 32'h0,
           32'h8001_1234, 0, 32'h2000, 4'b1111, 32'h0,
           1'b1, 32'h0000_8001);
    mem_op("lh", 32'h2000, MEM_SIZE_H, 1'b1, 1'b0, 32'h0,
           32'h8001_F234, 0, 32'h2000, 4'b1111, 32'h0,
           1'b1, 32'hFFFF_F234);
    mem_op("sh", 32'h3002, MEM_SIZE_H, 1'b0, 1'b1,
           32'hDEAD_BEEF, 32'h0, 0, 32'h3000, 4'b1100,
           32'hBEEF_BEEF, 1'b0, 32'h0);
    mem_op("sb", 32'h6001, MEM_SIZE_B, 1'b0, 1'b1,
           32'h1234_56A5, 32'h0, 0, 32'h6000, 4'b0010,
           32'hA5A5_A5A5, 1'b0, 32'h0);
    mem_op("sw_wait", 32'h4000, MEM_SIZE_W, 1'b0, 1'b1,
           32'hCAFE_F00D, 32'h0, 3, 32'h4000, 4'b1111,
           32'hCAFE_F00D, 1'b0, 32'h0);

    ex_if.valid    = 1'b1;
    ex_if.rd_we    = 1'b1;
    ex_if.rd       = 5'd9;
    ex_if.result   = 32'h4001;
    ex_if.mem_load = 1'b1;
    ex_if.mem_size = MEM_SIZE_W;
    #1;
    chk("mis.rdy", 32'(ex_if.ready), 32'd1);
    tick();
    idle_ex();
    chk("mis.reqv", 32'(dbus_req_valid), 32'd0);
    chk("mis.wbv", 32'(wb_valid), 32'd1);
    chk("mis.fault", 32'(wb_fault), 32'd1);
    chk("mis.rdwe", 32'(wb_rd_we), 32'd0);
    tick();
    chk("mis.wbv_once", 32'(wb_valid), 32'd0);

    ex_if.valid    = 1'b1;
    ex_if.rd_we    = 1'b1;
    ex_if.rd       = 5'd4;
    ex_if.result   = 32'h5000;
    ex_if.mem_load = 1'b1;
    ex_if.mem_size = MEM_SIZE_W;
    tick();
    dbus_req_ready = 1'b1;
    tick();
    dbus_req_ready = 1'b0;
    chk("rr.in_resp", 32'(dut.state_q), 32'(RESP));
    rst = 1'b1;
    #1;
    chk("rr.rdy_rst", 32'(ex_if.ready), 32'd0);
    tick();
    rst = 1'b0;
    idle_ex();
    chk("rr.state", 32'(dut.state_q), 32'(IDLE));
    chk("rr.reqv", 32'(dbus_req_valid), 32'd0);
    chk("rr.wbv", 32'(wb_valid), 32'd0);
    dbus_rsp_valid = 1'b1;
    dbus_rdata     = 32'hBAD0_BAD0;
    tick();
    dbus_rsp_valid = 1'b0;
    chk("rr.stray_wbv", 32'(wb_valid), 32'd0);
    chk("rr.stray_st", 32'(dut.state_q), 32'(IDLE));
    tick();
    chk("rr.stray_wbv2", 32'(wb_valid), 32'd0);
    mem_op("lw_after", 32'h5004, MEM_SIZE_W, 1'b0, 1'b0, 32'h0,
           32'h1234_5678, 0, 32'h5004, 4'b1111, 32'h0,
           1'b1, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
